dmem_bridge: RTL and testbench

//  Memory-stage data-bus bridge between the pipelined MIPS core and data RAM.
//  - Converts the core's single-cycle M-stage controls (memRead, memWriteM,

---
 rtl/dmem_bridge.sv | 178 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage bridge between the pipelined MIPS core and data RAM.
// A single-cycle M-stage load/store becomes a held req/ack bus transaction.
// stallM freezes the pipeline until the access completes. Each access takes
// IDLE -> REQ (one or more cycles) -> DONE.
// Optional feature: define DMEM_TIMEOUT_EN to abort a REQ phase after TIMEOUT
// cycles without ack. An abort sets the sticky err flag and returns ERR_DATA
// on a read.
module dmem_bridge #(
    parameter int                 DATA_W   = 32,
    parameter int                 TIMEOUT  = 15,
    parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] writeDataM,
    output logic [DATA_W-1:0] readDataM,
    output logic              stallM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            nextState_s;
    logic              stall_s;
    logic              capture_s;
    logic              timeout_s;
    logic              timeoutHit_s;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    logic [DATA_W-1:0] readData_r;

    // Clear the two byte-offset bits so the bus always sees a word address.
    function automatic logic [DATA_W-1:0] wordAddr(input logic [DATA_W-1:0] a);
        wordAddr = a & {{(DATA_W-2){1'b1}}, 2'b00};
    endfunction

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmoCnt_r;
    logic             err_r;

    // The TIMEOUT-th REQ cycle without ack aborts the access.
    assign timeoutHit_s = (tmoCnt_r == CNT_W'(TIMEOUT - 1));

    // Watchdog: cleared on REQ entry, counts REQ cycles that see no ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmoCnt_r <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            tmoCnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == REQ) && !bus_ack && !timeoutHit_s) begin
            tmoCnt_r <= tmoCnt_r + CNT_W'(1);
        end else begin
            tmoCnt_r <= tmoCnt_r;
        end
    end

    // Sticky abort flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    // There is no watchdog, so REQ waits for ack indefinitely and the abort
    // path can never be taken.
    assign timeoutHit_s = (TIMEOUT < 0);
    assign err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state and control decode. An ack wins over a simultaneous timeout.
    always_comb begin
        nextState_s = state_r;
        stall_s     = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (memReadM || memWriteM) begin
                    stall_s     = 1'b1;
                    capture_s   = 1'b1;
                    nextState_s = REQ;
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    nextState_s = DONE;
                end else if (timeoutHit_s) begin
                    timeout_s   = 1'b1;
                    nextState_s = DONE;
                end else begin
                    nextState_s = REQ;
                end
            end
            DONE: begin
                // The request still visible here is the one just served.
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Latch the transaction fields once; they stay stable through REQ.
    // A simultaneous read and write request is served as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= {DATA_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            we_r    <= 1'b0;
        end else if (capture_s) begin
            addr_r  <= wordAddr(ALUOutM);
            wdata_r <= writeDataM;
            we_r    <= memWriteM;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    // Load result: updated only by a completed or aborted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData_r <= {DATA_W{1'b0}};
        end else if ((state_r == REQ) && bus_ack && !we_r) begin
            readData_r <= bus_rdata;
        end else if (timeout_s && !we_r) begin
            readData_r <= ERR_DATA;
        end else begin
            readData_r <= readData_r;
        end
    end

    assign readDataM = readData_r;
    assign bus_req   = (state_r == REQ);
    assign bus_we    = we_r;
    assign bus_addr  = addr_r;
    assign bus_wdata = wdata_r;
    // Stall is forced low while reset is held so the pipeline is never frozen by it.
    assign stallM    = rst ? stall_s : 1'b0;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed, table-driven bench for dmem_bridge.
// One table row is one clock cycle. Inputs are applied just after the rising
// edge, and outputs are compared on the falling edge. Hand-written sequences
// cover reset in mid-transaction and the optional watchdog (DMEM_TIMEOUT_EN).
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM;
    logic        memWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] writeDataM;
    logic [31:0] readDataM;
    logic        stallM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        eStall;
        logic        eReq;
        logic        chkBus;
        logic        eWe;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eRd;
    } vec_t;

    vec_t vecs[20];

    dmem_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .memReadM   (memReadM),
        .memWriteM  (memWriteM),
        .ALUOutM    (ALUOutM),
        .writeDataM (writeDataM),
        .readDataM  (readDataM),
        .stallM     (stallM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                                input logic eStall, input logic eReq, input logic chkBus,
                                input logic eWe, input logic [31:0] eAddr,
                                input logic [31:0] eWdata, input logic [31:0] eRd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
        v.eStall = eStall; v.eReq = eReq; v.chkBus = chkBus; v.eWe = eWe;
        v.eAddr = eAddr; v.eWdata = eWdata; v.eRd = eRd;
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rd wr addr wdata ack rdata | stall req chkBus we addr wdata readDataM
        // Load with ack in the first REQ cycle; memReadM held in DONE is ignored.
        vecs[0]  = mk(1'b1, 1'b0, 32'h0000_1006, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0000_1006, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0000_1006, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        // Store with four wait cycles: req high 5 cycles, stall high 6.
        vecs[4]  = mk(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        for (int i = 5; i < 9; i++) begin
            vecs[i] = mk(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0F0F_0F0F,
                         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D);
        end
        vecs[9]  = mk(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D);
        vecs[10] = mk(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        // Stray ack while idle.
        vecs[11] = mk(1'b0, 1'b0, 32'h0,         32'h0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        // Read and write together -> write; ack during DONE is ignored.
        vecs[12] = mk(1'b1, 1'b1, 32'h0000_0043, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        vecs[13] = mk(1'b1, 1'b1, 32'h0000_0043, 32'hA5A5_A5A5, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'hCAFE_F00D);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         32'h0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        // Load at the top address with one wait cycle.
        vecs[16] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        vecs[17] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_0099, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D);
        vecs[18] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D);

        // Reset held with a stray ack: every output must be zero.
        rst = 1'b0; memReadM = 1'b0; memWriteM = 1'b0; ALUOutM = 32'h0;
        writeDataM = 32'h0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset readDataM", readDataM, 32'h0);
        chk("reset stallM",    {31'h0, stallM},  32'h0);
        chk("reset bus_req",   {31'h0, bus_req}, 32'h0);
        chk("reset bus_we",    {31'h0, bus_we},  32'h0);
        chk("reset bus_addr",  bus_addr,  32'h0);
        chk("reset bus_wdata", bus_wdata, 32'h0);
        chk("reset err",       {31'h0, err},     32'h0);
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        chk("post-reset stallM",  {31'h0, stallM},  32'h0);
        chk("post-reset bus_req", {31'h0, bus_req}, 32'h0);
        nextCycle();

        // Table-driven cycles.
        for (int i = 0; i < 20; i++) begin
            memReadM = vecs[i].rd; memWriteM = vecs[i].wr; ALUOutM = vecs[i].addr;
            writeDataM = vecs[i].wdata; bus_ack = vecs[i].ack; bus_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d stallM", i),    {31'h0, stallM},  {31'h0, vecs[i].eStall});
            chk($sformatf("v%0d bus_req", i),   {31'h0, bus_req}, {31'h0, vecs[i].eReq});
            chk($sformatf("v%0d readDataM", i), readDataM, vecs[i].eRd);
            chk($sformatf("v%0d err", i),       {31'h0, err}, 32'h0);
            if (vecs[i].chkBus) begin
                chk($sformatf("v%0d bus_we", i),    {31'h0, bus_we}, {31'h0, vecs[i].eWe});
                chk($sformatf("v%0d bus_addr", i),  bus_addr,  vecs[i].eAddr);
                chk($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].eWdata);
            end
            nextCycle();
        end

        // Reset during the second REQ cycle, with memReadM still high.
        memReadM = 1'b1; memWriteM = 1'b0; ALUOutM = 32'h0000_0200; bus_ack = 1'b0;
        nextCycle();
        nextCycle();
        chk("rst-mid req before", {31'h0, bus_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst-mid bus_req",   {31'h0, bus_req}, 32'h0);
        chk("rst-mid stallM",    {31'h0, stallM},  32'h0);
        chk("rst-mid readDataM", readDataM, 32'h0);
        nextCycle();
        rst = 1'b1; ALUOutM = 32'h0000_0300;
        @(negedge clk);
        chk("fresh idle stallM", {31'h0, stallM},  32'h1);
        chk("fresh idle req",    {31'h0, bus_req}, 32'h0);
        nextCycle();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("fresh req",      {31'h0, bus_req}, 32'h1);
        chk("fresh bus_addr", bus_addr, 32'h0000_0300);
        chk("fresh bus_we",   {31'h0, bus_we}, 32'h0);
        nextCycle();
        memReadM = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        chk("fresh readDataM", readDataM, 32'h0000_0077);
        chk("fresh done stall", {31'h0, stallM}, 32'h0);
        nextCycle();

`ifdef DMEM_TIMEOUT_EN
        // Read that never sees an ack: aborts after 15 REQ cycles.
        memReadM = 1'b1; ALUOutM = 32'h0000_0400; bus_ack = 1'b0;
        nextCycle();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("tmo req%0d", k), {31'h0, bus_req}, 32'h1);
            chk($sformatf("tmo err%0d", k), {31'h0, err},     32'h0);
            nextCycle();
        end
        memReadM = 1'b0;
        @(negedge clk);
        chk("tmo done err",       {31'h0, err},     32'h1);
        chk("tmo done readDataM", readDataM,        32'hDEAD_BEEF);
        chk("tmo done bus_req",   {31'h0, bus_req}, 32'h0);
        chk("tmo done stallM",    {31'h0, stallM},  32'h0);
        nextCycle();
        memReadM = 1'b1; ALUOutM = 32'h0000_0008;
        nextCycle();
        bus_ack = 1'b1; bus_rdata = 32'h0000_1234;
        nextCycle();
        memReadM = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        chk("post-tmo readDataM", readDataM, 32'h0000_1234);
        chk("post-tmo err sticky", {31'h0, err}, 32'h1);
        nextCycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
